// File: rtl/conv_pkg.sv
// conv_pkg: FSM encodings, kernel constants and counter-width helpers shared by the convolution path
package conv_pkg;

    localparam int KERNEL_W = 3;
    localparam int KERNEL_H = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    // Counter width for a range of n values; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_raster_cnt.sv
// conv_raster_cnt: raster row/col counter with line-buffer select and last-pixel flag
module conv_raster_cnt
    import conv_pkg::*;
#(
    parameter int Img_W = 512,
    parameter int Img_H = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       inc,
    output logic [cnt_w(Img_W)-1:0]    col,
    output logic [cnt_w(Img_H)-1:0]    row,
    output logic                       wsel,
    output logic                       last
);

    localparam int CW = cnt_w(Img_W);
    localparam int RW = cnt_w(Img_H);
    localparam logic [CW-1:0] COL_MAX = CW'(Img_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(Img_H - 1);

    logic col_end;

    assign col_end = col == COL_MAX;
    assign last    = col_end && row == ROW_MAX;

    // Advance one pixel per increment; the row holds at the last row so the frame never wraps
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            col  <= '0;
            row  <= '0;
            wsel <= 1'b0;
        end else if (inc) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end && !last) begin
                row  <= row + 1'b1;
                wsel <= ~wsel;
            end
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: raster-scan pixel intake, line-buffer write control and 3x3 window scheduling
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int Img_H     = 512,
    parameter int K_W       = KERNEL_W,
    parameter int K_H       = KERNEL_H
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [Datawidth-1:0]       pix_data,
    output logic [1:0]                 lb_we,
    output logic [cnt_w(Img_W)-1:0]    lb_addr,
    output logic [Datawidth-1:0]       lb_wdata,
    output logic                       win_valid,
    output logic [cnt_w(Img_H)-1:0]    win_row,
    output logic [cnt_w(Img_W)-1:0]    win_col,
    input  logic                       mac_ready,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int CW = cnt_w(Img_W);
    localparam int RW = cnt_w(Img_H);
    localparam logic [RW-1:0] ROW_OFS = RW'(K_H - 1);
    localparam logic [CW-1:0] COL_OFS = CW'(K_W - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          wsel;
    logic          last;
    logic          accept;
    logic          consume;
    logic          fire;
    logic          clr;

    assign busy      = state != S_IDLE;
    assign pix_ready = state == S_RUN && (!win_valid || mac_ready);
    assign accept    = pix_valid && pix_ready;
    assign consume   = win_valid && mac_ready;
    assign fire      = accept && row >= ROW_OFS && col >= COL_OFS;
    assign clr       = state == S_IDLE && start;

    conv_raster_cnt #(
        .Img_W (Img_W),
        .Img_H (Img_H)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (accept),
        .col   (col),
        .row   (row),
        .wsel  (wsel),
        .last  (last)
    );

    // Frame sequencing: idle until start, run until the last pixel, drain until its window is taken
    always_comb begin
        next_state = (state == S_IDLE && start)              ? S_RUN   :
                     (state == S_RUN && accept && last)      ? S_DRAIN :
                     (state == S_DRAIN && consume)           ? S_IDLE  : state;
    end

    // State register and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            frame_done <= state == S_DRAIN && consume;
        end
    end

    // Line-buffer write port: one-hot enable only in the accept cycle, address/data hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            lb_we    <= 2'b00;
            lb_addr  <= '0;
            lb_wdata <= '0;
        end else begin
            lb_we <= accept ? (wsel ? 2'b10 : 2'b01) : 2'b00;
            if (accept) begin
                lb_addr  <= col;
                lb_wdata <= pix_data;
            end
        end
    end

    // Window descriptor: a newly fired window wins over consumption of the previous one
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= fire || (win_valid && !mac_ready);
            if (fire) begin
                win_row <= row - ROW_OFS;
                win_col <= col - COL_OFS;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: directed 5x5 frames against a scoreboard of expected windows and line-buffer writes
module tb_conv_window_sched;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic [1:0]    lb_we;
    logic [CW-1:0] lb_addr;
    logic [DW-1:0] lb_wdata;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          mac_ready;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    conv_window_sched #(
        .Datawidth (DW),
        .Img_W     (W),
        .Img_H     (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .mac_ready  (mac_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_state = 0;
    int          m_row = 0;
    int          m_col = 0;
    int          m_wsel = 0;
    int          m_accepts = 0;
    logic [1:0]  e_we = 2'b00;
    logic [31:0] e_addr = 0;
    logic [31:0] e_wdata = 0;
    logic        e_done = 1'b0;
    int          q[$];
    int          dut_wins = 0;
    int          dut_dones = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rs, input logic v, input logic st, input logic mr, input logic [7:0] d);
        logic pr;
        logic acc;
        logic cons;
        reset     = rs;
        pix_valid = v;
        start     = st;
        mac_ready = mr;
        pix_data  = d;
        #1;
        pr = m_state == 1 && (q.size() == 0 || mr);
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("win_valid", 32'(win_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("win_row", 32'(win_row), 32'(q[0] / 256));
            chk("win_col", 32'(win_col), 32'(q[0] % 256));
        end
        chk("lb_we", 32'(lb_we), 32'(e_we));
        chk("lb_addr", 32'(lb_addr), e_addr);
        chk("lb_wdata", 32'(lb_wdata), e_wdata);
        chk("pix_ready", 32'(pix_ready), 32'(pr));
        if (frame_done === 1'b1) dut_dones++;
        if (win_valid === 1'b1 && mr) dut_wins++;
        if (rs) begin
            m_state = 0;
            q.delete();
            e_we    = 2'b00;
            e_addr  = 0;
            e_wdata = 0;
            e_done  = 1'b0;
        end else begin
            acc    = v && pr;
            cons   = q.size() != 0 && mr;
            e_done = m_state == 2 && cons;
            if (cons) void'(q.pop_front());
            e_we = acc ? (m_wsel != 0 ? 2'b10 : 2'b01) : 2'b00;
            if (acc) begin
                e_addr  = m_col;
                e_wdata = 32'(d);
                m_accepts++;
                if (m_row >= 2 && m_col >= 2) q.push_back((m_row - 2) * 256 + (m_col - 2));
            end
            if (m_state == 0 && st) begin
                m_state = 1;
                m_row   = 0;
                m_col   = 0;
                m_wsel  = 0;
            end else if (m_state == 1 && acc) begin
                if (m_row == H - 1 && m_col == W - 1) m_state = 2;
                else if (m_col == W - 1) begin
                    m_col  = 0;
                    m_row++;
                    m_wsel ^= 1;
                end else m_col++;
            end else if (m_state == 2 && cons) m_state = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // One frame: optional random pixel gaps, MAC stall on window (1,1), stray start, mid-frame reset
    task automatic frame(input bit gaps, input int stall_n, input int start_at, input int reset_at);
        int  base;
        int  stall;
        int  n;
        int  w0;
        int  d0;
        logic mr;
        logic v;
        tick(0, 0, 1, 1, 8'h00);
        base  = m_accepts;
        w0    = dut_wins;
        d0    = dut_dones;
        stall = 0;
        n     = 0;
        while (m_state != 0 && n < 400) begin
            if (reset_at >= 0 && m_accepts - base == reset_at) begin
                tick(1, 1, 0, 1, 8'h5A);
                tick(0, 0, 0, 1, 8'h00);
                return;
            end
            mr = 1'b1;
            if (q.size() != 0 && q[0] == 257 && stall < stall_n) begin
                mr = 1'b0;
                stall++;
            end
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(0, v, (m_accepts - base) == start_at, mr, 8'($urandom));
            n++;
        end
        chk("frame_within_budget", 32'(n < 400), 32'd1);
        tick(0, 0, 0, 1, 8'h00);
        chk("pixels_accepted", 32'(m_accepts - base), 32'(W * H));
        chk("windows_per_frame", 32'(dut_wins - w0), 32'((W - 2) * (H - 2)));
        chk("frame_done_pulses", 32'(dut_dones - d0), 32'd1);
        chk("stall_cycles_seen", 32'(stall), 32'(stall_n));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        mac_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick(1, 0, 0, 1, 8'h00);
        tick(0, 1, 0, 1, 8'hAA);
        tick(0, 1, 0, 1, 8'hBB);
        frame(0, 0, -1, -1);
        frame(0, 4, -1, -1);
        frame(1, 0, 7, -1);
        frame(1, 0, -1, 12);
        frame(0, 0, -1, -1);
        frame(1, 3, 20, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
